// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser plus independent per-bit debounce counters; SW_DEBOUNCE_EDGE_EN adds sw_rise/sw_fall
module sw_debounce #(
  parameter int WIDTH         = 8,
  parameter int CNT_W         = 16,
  parameter int STABLE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw,
  output logic             sw_change,
  output logic             sw_stable
`ifdef SW_DEBOUNCE_EDGE_EN
  ,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
`endif
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  logic [WIDTH-1:0] s1_q, s2_q, sw_q, sw_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic change_q, stable_q, stable_d;
  // a bit's counter runs while its synchronised level differs from sw; reaching LAST accepts the new level
  always_comb begin
    sw_d = sw_q;
    stable_d = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = (s2_q[i] == sw_q[i] || cnt_q[i] == LAST) ? '0 : cnt_q[i] + CNT_W'(1);
      sw_d[i] = (s2_q[i] != sw_q[i] && cnt_q[i] == LAST) ? s2_q[i] : sw_q[i];
      stable_d = stable_d & (cnt_d[i] == '0);
    end
  end
  // synchroniser, counters and registered status; reset overrides a same-edge acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      sw_q <= '0;
      cnt_q <= '{default: '0};
      change_q <= 1'b0;
      stable_q <= 1'b1;
    end else begin
      s1_q <= sw_raw;
      s2_q <= s1_q;
      sw_q <= sw_d;
      cnt_q <= cnt_d;
      change_q <= sw_d != sw_q;
      stable_q <= stable_d;
    end
  end
  assign sw = sw_q;
  assign sw_change = change_q;
  assign sw_stable = stable_q;
`ifdef SW_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] rise_q, fall_q;
  // per-bit edge pulses, aligned with sw_change
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= sw_d & ~sw_q;
      fall_q <= ~sw_d & sw_q;
    end
  end
  assign sw_rise = rise_q;
  assign sw_fall = fall_q;
`endif
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed stimulus with a history-based debounce model and literal spot checks
module tb_sw_debounce;
  localparam int W = 8;
  localparam int ST = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw;
  logic sw_change, sw_stable;
`ifdef SW_DEBOUNCE_EDGE_EN
  logic [W-1:0] sw_rise, sw_fall;
`endif
  int checks = 0;
  int errors = 0;

  sw_debounce #(.WIDTH(W), .CNT_W(16), .STABLE_CYCLES(ST)) dut (
    .clk(clk),
    .rst(rst),
    .sw_raw(sw_raw),
    .sw(sw),
    .sw_change(sw_change),
    .sw_stable(sw_stable)
`ifdef SW_DEBOUNCE_EDGE_EN
    ,
    .sw_rise(sw_rise),
    .sw_fall(sw_fall)
`endif
  );

  always #5 clk = ~clk;

  // model: the level seen downstream is sw_raw delayed two edges; a bit flips once its
  // last ST seen levels all disagree with the current debounced value
  logic [W-1:0] m_p1 = '0, m_p2 = '0, m_sw = '0, m_rise = '0, m_fall = '0;
  logic m_chg = 1'b0, m_stb = 1'b1, m_valid = 1'b0;
  logic [W-1:0] hist[$];

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      m_p1 = '0;
      m_p2 = '0;
      m_sw = '0;
      m_chg = 1'b0;
      m_stb = 1'b1;
      m_rise = '0;
      m_fall = '0;
      m_valid = 1'b1;
    end else begin
      logic [W-1:0] nsw;
      logic stb;
      hist.push_back(m_p2);
      if (hist.size() > ST) void'(hist.pop_front());
      nsw = m_sw;
      stb = 1'b1;
      for (int i = 0; i < W; i++) begin
        int run;
        run = 0;
        for (int j = hist.size() - 1; j >= 0; j--) begin
          if (hist[j][i] == m_sw[i]) break;
          run++;
        end
        if (run >= ST) nsw[i] = ~m_sw[i];
        else if (run > 0) stb = 1'b0;
      end
      m_rise = nsw & ~m_sw;
      m_fall = ~nsw & m_sw;
      m_chg = nsw != m_sw;
      m_sw = nsw;
      m_stb = stb;
      m_p2 = m_p1;
      m_p1 = sw_raw;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_sw", sw, m_sw);
      chk("model_change", W'(sw_change), W'(m_chg));
      chk("model_stable", W'(sw_stable), W'(m_stb));
`ifdef SW_DEBOUNCE_EDGE_EN
      chk("model_rise", sw_rise, m_rise);
      chk("model_fall", sw_fall, m_fall);
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    step(2);
    chk("reset_sw", sw, 8'h00);
    chk("reset_change", W'(sw_change), 8'h00);
    chk("reset_stable", W'(sw_stable), 8'h01);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      chk("idle_sw", sw, 8'h00);
      chk("idle_change", W'(sw_change), 8'h00);
      chk("idle_stable", W'(sw_stable), 8'h01);
    end
    sw_raw = 8'h05;
    step(2);
    chk("p05_sw_k1", sw, 8'h00);
    chk("p05_stable_k1", W'(sw_stable), 8'h01);
    for (int c = 0; c < 3; c++) begin
      step(1);
      chk("p05_sw_wait", sw, 8'h00);
      chk("p05_stable_low", W'(sw_stable), 8'h00);
    end
    step(1);
    chk("p05_sw_upd", sw, 8'h05);
    chk("p05_change", W'(sw_change), 8'h01);
    chk("p05_stable_up", W'(sw_stable), 8'h01);
    step(1);
    chk("p05_change_end", W'(sw_change), 8'h00);
    for (int t = 0; t < 4; t++) begin
      sw_raw = t[0] ? 8'h05 : 8'h85;
      for (int c = 0; c < 2; c++) begin
        step(1);
        chk("toggle_sw", sw, 8'h05);
        chk("toggle_change", W'(sw_change), 8'h00);
      end
    end
    sw_raw = 8'h85;
    step(5);
    chk("hold7_sw_wait", sw, 8'h05);
    step(1);
    chk("hold7_sw_upd", sw, 8'h85);
    chk("hold7_change", W'(sw_change), 8'h01);
    sw_raw = 8'h00;
    step(8);
    chk("clear_sw", sw, 8'h00);
    sw_raw = 8'hFF;
    step(5);
    chk("ff_sw_wait", sw, 8'h00);
    step(1);
    chk("ff_sw_upd", sw, 8'hFF);
    chk("ff_change", W'(sw_change), 8'h01);
`ifdef SW_DEBOUNCE_EDGE_EN
    chk("ff_rise", sw_rise, 8'hFF);
    chk("ff_fall", sw_fall, 8'h00);
`endif
    step(1);
    chk("ff_change_end", W'(sw_change), 8'h00);
    sw_raw = 8'h00;
    step(8);
    sw_raw = 8'h08;
    step(5);
    chk("rst_mid_pending", W'(sw_stable), 8'h00);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst_mid_sw", sw, 8'h00);
    chk("rst_mid_stable", W'(sw_stable), 8'h01);
    chk("rst_mid_change", W'(sw_change), 8'h00);
    step(5);
    chk("rst_after_wait", sw, 8'h00);
    step(1);
    chk("rst_after_upd", sw, 8'h08);
    chk("rst_after_change", W'(sw_change), 8'h01);
    sw_raw = 8'h80;
    step(8);
    chk("glitch_pre_sw", sw, 8'h80);
    sw_raw = 8'h00;
    step(1);
    sw_raw = 8'h80;
    step(1);
    chk("glitch_stable_k1", W'(sw_stable), 8'h01);
    step(1);
    chk("glitch_stable_dip", W'(sw_stable), 8'h00);
    chk("glitch_sw_dip", sw, 8'h80);
    step(1);
    chk("glitch_stable_back", W'(sw_stable), 8'h01);
    for (int c = 0; c < 6; c++) begin
      step(1);
      chk("glitch_sw", sw, 8'h80);
      chk("glitch_change", W'(sw_change), 8'h00);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Switch conditioning stage that sits directly upstream of the 8-bit priority encoder.
- Synchronises raw slide-switch inputs into the clk domain and debounces each bit independently.
- Presents a clean, glitch-free switch vector to the encoder's sw input.
- Also provides a change pulse and a settled flag, so downstream logic can sample only on real transitions.

Parameters:
- WIDTH, 8, number of switch bits conditioned.
- CNT_W, 16, width of each per-bit stability counter.
- STABLE_CYCLES, 50000, number of consecutive clk cycles a changed level must persist before it is accepted. Legal range is 1 to 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- sw_raw  input  WIDTH  asynchronous raw switch levels.
- sw  output  WIDTH  debounced switch vector, fed to the encoder's sw.
- sw_change  output  1  one-cycle pulse on the cycle any bit of sw updates.
- sw_stable  output  1  high when every bit's counter is zero, i.e. no pending transition.

Behaviour:
- Reset: one clock, synchronous and active-high. On the rising clk edge with rst=1:
  - sync stages cleared to 0.
  - all counters cleared to 0.
  - sw=0, sw_change=0, sw_stable=1.
  - rst has priority over every other event, including a pending acceptance on the same edge. Reset mid-count discards the pending transition.
- Synchroniser: two flops per bit, s1 <= sw_raw, s2 <= s1. Only s2 is used downstream. No combinational path from sw_raw to any output.
- Per-bit counter i, evaluated on each edge:
  - If s2[i]==sw[i]: cnt[i] <= 0 (bounce or return to the old level restarts the window).
  - Else if cnt[i]==STABLE_CYCLES-1: sw[i] <= s2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - The counter never exceeds STABLE_CYCLES-1, so no wrap-around is possible.
- Latency: a clean level change on sw_raw set up before edge k appears on sw after edge k+1+STABLE_CYCLES. With STABLE_CYCLES=1 this is edge k+2.
- Bits are fully independent. Several bits may update on the same edge.
- sw_change:
  - Registered; high for exactly the one cycle following any edge on which at least one sw bit changed.
  - Simultaneous updates of several bits give a single pulse.
  - Back-to-back updates on different bits in consecutive cycles give sw_change high for consecutive cycles.
- sw_stable:
  - Registered; equals the AND over all bits of (next cnt==0), so it is coincident with the state after the edge.
  - Drops on the first edge a bit starts counting.
  - Rises on the edge the last pending bit is accepted or cancelled.
- A pulse on sw_raw shorter than STABLE_CYCLES cycles (after synchronisation) never reaches sw. sw_change stays 0 in that case.

Optional Feature:
- Macro SW_DEBOUNCE_EDGE_EN.
- When defined, two extra output ports are added:
  - sw_rise output WIDTH: one-cycle per-bit pulses, registered and coincident with sw_change. sw_rise[i]=1 when sw[i] went 0->1 on that edge.
  - sw_fall output WIDTH: the same for a 1->0 change.
  - Both outputs reset to 0.
- When not defined, these ports and their logic do not exist. All other behaviour is identical.

Test Plan (STABLE_CYCLES=4, WIDTH=8):
- Reset then idle, sw_raw=8'h00 -> sw=8'h00, sw_change=0, sw_stable=1 for 20 cycles.
- Drive sw_raw=8'h05 cleanly before edge 10 -> sw stays 8'h00 through edge 14 and becomes 8'h05 after edge 15. sw_change is high for exactly that one cycle. sw_stable is low from edge 12 to edge 14 and high again after edge 15.
- Toggle sw_raw[7] as 1,0,1,0 every 2 cycles, then hold at 1 -> no change on sw during the toggling. sw[7]=1 exactly 5 cycles after the final rising level. One sw_change pulse total.
- Change sw_raw from 8'h00 to 8'hFF on a single edge -> all 8 bits update on the same edge to 8'hFF with a single sw_change pulse. With SW_DEBOUNCE_EDGE_EN: sw_rise=8'hFF and sw_fall=8'h00 on that cycle.
- Assert rst for 1 cycle while bit 3 has counted 3 of 4 -> sw=8'h00 and the counter is cleared. With sw_raw still 8'h08, sw=8'h08 appears 5 cycles after rst deasserts (6th edge from the reset edge).
- With sw=8'h80 settled, drive a 1-cycle 0 glitch on sw_raw[7] -> sw remains 8'h80, sw_change=0. sw_stable dips low for exactly 1 cycle.
